// File: rtl/mem_stage.sv
// Memory pipeline stage: M pipeline register, data-bus load/store sequencer,
// load alignment/extension, store strobe generation and address-error detection.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              M_stall,
    input  logic              M_bubble,
    input  logic              exception,
    input  logic [31:0]       M_pc,
    input  logic [31:0]       M_val3,
    input  logic [31:0]       M_valt,
    input  logic [5:0]        M_icode,
    input  logic [5:0]        M_acode,
    input  logic [5:0]        M_excCode,
    input  logic [4:0]        M_dst,
    input  logic              M_inDelaySlot,
    output logic              dreq_valid,
    output logic              dreq_write,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_wdata,
    input  logic              daddr_ok,
    input  logic              ddata_ok,
    input  logic [DATA_W-1:0] drdata,
    output logic [31:0]       m_pc,
    output logic [31:0]       m_val,
    output logic [5:0]        m_icode,
    output logic [5:0]        m_acode,
    output logic [4:0]        m_dst,
    output logic [5:0]        m_excCode,
    output logic              m_inDelaySlot,
    output logic [31:0]       m_badvaddr,
    output logic              m_busy
);

    // Memory opcodes shared with the decode stage.
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Address-error codes with the valid bit (bit 5) set.
    localparam logic [5:0] EXC_ADEL = 6'b100100;
    localparam logic [5:0] EXC_ADES = 6'b100101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input logic [5:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // M pipeline register and sequencer state.
    state_e      state_q,  state_d;
    logic        cancel_q, cancel_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] val3_q,   val3_d;
    logic [31:0] valt_q,   valt_d;
    logic [5:0]  icode_q,  icode_d;
    logic [5:0]  acode_q,  acode_d;
    logic [5:0]  exc_q,    exc_d;
    logic [4:0]  dst_q,    dst_d;
    logic        ds_q,     ds_d;
    logic [31:0] badv_q,   badv_d;

    // Decode of the incoming instruction, evaluated at capture time.
    logic        in_load;
    logic        in_store;
    logic        in_fault;
    logic        in_start;
    logic [5:0]  in_exc;
    logic [31:0] in_badv;
    logic        busy;
    logic        reg_load;

    assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
    // A bus transaction in flight freezes the register so its address and data stay stable.
    assign reg_load = !busy && !M_stall;

    // Classify the incoming op and resolve its final exception code.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        in_load  = is_load(M_icode);
        in_store = is_store(M_icode);
        in_fault = (is_half(M_icode) && M_val3[0]) ||
                   (is_word(M_icode) && (M_val3[1:0] != 2'b00));
        in_exc   = M_excCode;
        in_badv  = 32'h0;
        if (!M_excCode[5] && in_fault) begin
            in_exc  = in_load ? EXC_ADEL : EXC_ADES;
            in_badv = M_val3;
        end
        in_start = (in_load || in_store) && !M_excCode[5] && !in_fault;
    end

    // Next value of the M register: busy-hold, then stall, then bubble, then capture.
    always_comb begin
        pc_d    = pc_q;
        val3_d  = val3_q;
        valt_d  = valt_q;
        icode_d = icode_q;
        acode_d = acode_q;
        exc_d   = exc_q;
        dst_d   = dst_q;
        ds_d    = ds_q;
        badv_d  = badv_q;
        if (reg_load) begin
            if (M_bubble) begin
                pc_d    = 32'h0;
                val3_d  = 32'h0;
                valt_d  = 32'h0;
                icode_d = 6'h0;
                acode_d = 6'h0;
                exc_d   = 6'h0;
                dst_d   = 5'h0;
                ds_d    = 1'b0;
                badv_d  = 32'h0;
            end else begin
                pc_d    = M_pc;
                val3_d  = M_val3;
                valt_d  = M_valt;
                icode_d = M_icode;
                acode_d = M_acode;
                exc_d   = in_exc;
                dst_d   = M_dst;
                ds_d    = M_inDelaySlot;
                badv_d  = in_badv;
            end
        end
    end

    // Bus sequencer next state: issue, wait for accept, wait for data, cancel on flush.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                cancel_d = 1'b0;
                if (reg_load) begin
                    state_d = (!M_bubble && in_start) ? S_REQ : S_IDLE;
                end
            end
            S_REQ: begin
                if (daddr_ok) begin
                    if (ddata_ok) begin
                        // An accepted request cannot be withdrawn; a flush only discards it.
                        if (exception) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DONE;
                            rdata_d = drdata;
                        end
                    end else begin
                        state_d  = S_WAIT;
                        cancel_d = exception;
                    end
                end else if (exception) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (ddata_ok) begin
                    cancel_d = 1'b0;
                    if (cancel_q || exception) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = drdata;
                    end
                end else if (exception) begin
                    cancel_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and pipeline register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
            rdata_q  <= 32'h0;
            pc_q     <= 32'h0;
            val3_q   <= 32'h0;
            valt_q   <= 32'h0;
            icode_q  <= 6'h0;
            acode_q  <= 6'h0;
            exc_q    <= 6'h0;
            dst_q    <= 5'h0;
            ds_q     <= 1'b0;
            badv_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            rdata_q  <= rdata_d;
            pc_q     <= pc_d;
            val3_q   <= val3_d;
            valt_q   <= valt_d;
            icode_q  <= icode_d;
            acode_q  <= acode_d;
            exc_q    <= exc_d;
            dst_q    <= dst_d;
            ds_q     <= ds_d;
            badv_q   <= badv_d;
        end
    end

    // Load data alignment and sign/zero extension from the captured response.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        byte_sel = 8'h0;
        case (val3_q[1:0])
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = val3_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_val = rdata_q;
        case (icode_q)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h0, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0, half_sel};
            default: load_val = rdata_q;
        endcase
    end

    // Store strobes and lane-replicated write data from the held register.
    always_comb begin
        dreq_strobe = 4'b0000;
        dreq_wdata  = '0;
        case (icode_q)
            OP_SB: begin
                dreq_strobe = 4'b0001 << val3_q[1:0];
                dreq_wdata  = {4{valt_q[7:0]}};
            end
            OP_SH: begin
                dreq_strobe = val3_q[1] ? 4'b1100 : 4'b0011;
                dreq_wdata  = {2{valt_q[15:0]}};
            end
            OP_SW: begin
                dreq_strobe = 4'b1111;
                dreq_wdata  = valt_q;
            end
            default: begin
                dreq_strobe = 4'b0000;
                dreq_wdata  = '0;
            end
        endcase
    end

    assign dreq_valid    = (state_q == S_REQ);
    assign dreq_write    = is_store(icode_q);
    assign dreq_addr     = {val3_q[ADDR_W-1:2], 2'b00};

    assign m_busy        = busy;
    assign m_pc          = pc_q;
    // Load results become visible only once the response has been captured.
    assign m_val         = ((state_q == S_DONE) && is_load(icode_q)) ? load_val : val3_q;
    assign m_icode       = icode_q;
    assign m_acode       = acode_q;
    assign m_dst         = dst_q;
    assign m_excCode     = exc_q;
    assign m_inDelaySlot = ds_q;
    assign m_badvaddr    = badv_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, alignment faults, bus stalls and flushes.
module tb_mem_stage;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        resetn, M_stall, M_bubble, exception;
    logic [31:0] M_pc, M_val3, M_valt;
    logic [5:0]  M_icode, M_acode, M_excCode;
    logic [4:0]  M_dst;
    logic        M_inDelaySlot;
    logic        dreq_valid, dreq_write;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_strobe;
    logic        daddr_ok, ddata_ok;
    logic [31:0] drdata;
    logic [31:0] m_pc, m_val, m_badvaddr;
    logic [5:0]  m_icode, m_acode, m_excCode;
    logic [4:0]  m_dst;
    logic        m_inDelaySlot, m_busy;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .resetn(resetn), .M_stall(M_stall), .M_bubble(M_bubble),
        .exception(exception), .M_pc(M_pc), .M_val3(M_val3), .M_valt(M_valt),
        .M_icode(M_icode), .M_acode(M_acode), .M_excCode(M_excCode), .M_dst(M_dst),
        .M_inDelaySlot(M_inDelaySlot), .dreq_valid(dreq_valid), .dreq_write(dreq_write),
        .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
        .daddr_ok(daddr_ok), .ddata_ok(ddata_ok), .drdata(drdata), .m_pc(m_pc),
        .m_val(m_val), .m_icode(m_icode), .m_acode(m_acode), .m_dst(m_dst),
        .m_excCode(m_excCode), .m_inDelaySlot(m_inDelaySlot), .m_badvaddr(m_badvaddr),
        .m_busy(m_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic instr(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] val3,
                         input logic [31:0] valt, input logic [5:0] exc);
        M_icode = op; M_pc = pc; M_val3 = val3; M_valt = valt; M_excCode = exc;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        daddr_ok = aok; ddata_ok = dok; drdata = rd;
    endtask

    // Capture a load, complete it with same-cycle addr_ok/data_ok, leave FSM in DONE.
    task automatic load_once(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd);
        instr(op, 32'h500, addr, 32'h0, 6'h0);
        bus(1'b0, 1'b0, 32'h0);
        tick();
        check("ld_req_valid", 32'(dreq_valid), 32'd1);
        bus(1'b1, 1'b1, rd);
        instr(OP_NOP, 32'h504, 32'h0, 32'h0, 6'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; exception = 1'b0;
        M_acode = 6'h11; M_dst = 5'd7; M_inDelaySlot = 1'b1;
        instr(OP_LW, 32'hAAAA_0000, 32'h1234_5678, 32'h5555_5555, 6'h0);
        bus(1'b1, 1'b1, 32'hFFFF_FFFF);
        tick(); tick();
        check("rst_m_pc", m_pc, 32'h0);
        check("rst_m_val", m_val, 32'h0);
        check("rst_m_exc", 32'(m_excCode), 32'h0);
        check("rst_m_dst", 32'(m_dst), 32'h0);
        check("rst_busy", 32'(m_busy), 32'h0);
        check("rst_dreq_valid", 32'(dreq_valid), 32'h0);

        // LB from byte 3, sign extended, minimum latency.
        resetn = 1'b1;
        instr(OP_LB, 32'h100, 32'h1003, 32'h0, 6'h0);
        bus(1'b0, 1'b0, 32'h0);
        tick();
        check("lb_valid", 32'(dreq_valid), 32'd1);
        check("lb_addr", dreq_addr, 32'h1000);
        check("lb_strobe", 32'(dreq_strobe), 32'h0);
        check("lb_write", 32'(dreq_write), 32'h0);
        check("lb_busy", 32'(m_busy), 32'd1);
        check("lb_dst", 32'(m_dst), 32'd7);
        instr(OP_NOP, 32'h104, 32'h55, 32'h0, 6'h0);
        bus(1'b1, 1'b1, 32'h80FF_FF12);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        check("lb_val", m_val, 32'hFFFF_FF80);
        check("lb_done_busy", 32'(m_busy), 32'h0);
        check("lb_done_valid", 32'(dreq_valid), 32'h0);
        check("lb_pc", m_pc, 32'h100);

        // Non-memory passthrough.
        tick();
        check("nop_val", m_val, 32'h55);
        check("nop_busy", 32'(m_busy), 32'h0);
        check("nop_valid", 32'(dreq_valid), 32'h0);

        load_once(OP_LBU, 32'h1003, 32'h80FF_FF12);
        check("lbu_val", m_val, 32'h0000_0080);
        load_once(OP_LH, 32'h1002, 32'h80FF_FF12);
        check("lh_val", m_val, 32'hFFFF_80FF);
        load_once(OP_LHU, 32'h1002, 32'h80FF_FF12);
        check("lhu_val", m_val, 32'h0000_80FF);
        load_once(OP_LB, 32'h1001, 32'h80FF_FF12);
        check("lb1_val", m_val, 32'hFFFF_FFFF);
        load_once(OP_LW, 32'h1000, 32'h8765_4321);
        check("lw_val", m_val, 32'h8765_4321);

        // SH to upper half.
        instr(OP_SH, 32'h10C, 32'h2002, 32'h1234_ABCD, 6'h0);
        tick();
        check("sh_valid", 32'(dreq_valid), 32'd1);
        check("sh_write", 32'(dreq_write), 32'd1);
        check("sh_addr", dreq_addr, 32'h2000);
        check("sh_strobe", 32'(dreq_strobe), 32'hC);
        check("sh_wdata", dreq_wdata, 32'hABCD_ABCD);
        instr(OP_NOP, 32'h110, 32'h0, 32'h0, 6'h0);
        bus(1'b1, 1'b1, 32'hDEAD_DEAD);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        check("sh_mval", m_val, 32'h2002);
        check("sh_done_busy", 32'(m_busy), 32'h0);

        // SB to byte 1.
        instr(OP_SB, 32'h114, 32'h2001, 32'h0000_00EF, 6'h0);
        tick();
        check("sb_strobe", 32'(dreq_strobe), 32'h2);
        check("sb_wdata", dreq_wdata, 32'hEFEF_EFEF);
        instr(OP_NOP, 32'h118, 32'h0, 32'h0, 6'h0);
        bus(1'b1, 1'b1, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);

        // Alignment faults.
        instr(OP_LW, 32'h120, 32'h3001, 32'h0, 6'h0);
        tick();
        check("lw_ade_valid", 32'(dreq_valid), 32'h0);
        check("lw_ade_busy", 32'(m_busy), 32'h0);
        check("lw_ade_code", 32'(m_excCode), 32'h24);
        check("lw_ade_badv", m_badvaddr, 32'h3001);
        instr(OP_SW, 32'h124, 32'h3001, 32'h0, 6'h0);
        tick();
        check("sw_ade_valid", 32'(dreq_valid), 32'h0);
        check("sw_ade_code", 32'(m_excCode), 32'h25);
        check("sw_ade_badv", m_badvaddr, 32'h3001);
        instr(OP_LH, 32'h128, 32'h3003, 32'h0, 6'h0);
        tick();
        check("lh_ade_code", 32'(m_excCode), 32'h24);

        // Incoming exception wins over alignment and suppresses the request.
        instr(OP_NOP, 32'h12C, 32'h4000, 32'h0, 6'b101100);
        tick();
        check("add_exc_code", 32'(m_excCode), 32'h2C);
        check("add_exc_badv", m_badvaddr, 32'h0);
        check("add_exc_valid", 32'(dreq_valid), 32'h0);
        check("add_exc_busy", 32'(m_busy), 32'h0);
        instr(OP_LW, 32'h130, 32'h3001, 32'h0, 6'b101010);
        tick();
        check("lw_inexc_code", 32'(m_excCode), 32'h2A);
        check("lw_inexc_badv", m_badvaddr, 32'h0);
        check("lw_inexc_valid", 32'(dreq_valid), 32'h0);

        // LW with addr_ok on the 4th REQ cycle, data_ok two cycles later; busy overrides bubble.
        instr(OP_LW, 32'h200, 32'h5008, 32'h0, 6'h0);
        tick();
        vcnt = 32'(dreq_valid);
        check("dly_busy_req", 32'(m_busy), 32'd1);
        instr(OP_NOP, 32'h999, 32'h777, 32'h0, 6'h0);
        M_bubble = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vcnt += 32'(dreq_valid);
        end
        check("dly_hold_pc", m_pc, 32'h200);
        check("dly_hold_addr", dreq_addr, 32'h5008);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        vcnt += 32'(dreq_valid);
        check("dly_wait_busy", 32'(m_busy), 32'd1);
        bus(1'b0, 1'b0, 32'h0);
        tick();
        vcnt += 32'(dreq_valid);
        check("dly_wait_busy2", 32'(m_busy), 32'd1);
        bus(1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        check("dly_valid_cycles", 32'(vcnt), 32'd4);
        check("dly_val", m_val, 32'hCAFE_F00D);
        check("dly_pc", m_pc, 32'h200);
        check("dly_done_busy", 32'(m_busy), 32'h0);

        // Bubble zeroes the register once not busy.
        tick();
        check("bubble_pc", m_pc, 32'h0);
        check("bubble_val", m_val, 32'h0);
        M_bubble = 1'b0;

        // Stall holds, release captures.
        instr(OP_NOP, 32'h600, 32'h1234, 32'h0, 6'h0);
        M_stall = 1'b1;
        tick();
        check("stall_hold_pc", m_pc, 32'h0);
        M_stall = 1'b0;
        tick();
        check("stall_rel_pc", m_pc, 32'h600);

        // Flush before addr_ok drops the store request.
        instr(OP_SW, 32'h300, 32'h6004, 32'hDEAD_BEEF, 6'h0);
        tick();
        check("exreq_valid", 32'(dreq_valid), 32'd1);
        instr(OP_NOP, 32'h304, 32'h0, 32'h0, 6'h0);
        exception = 1'b1;
        tick();
        exception = 1'b0;
        check("exreq_drop_valid", 32'(dreq_valid), 32'h0);
        check("exreq_drop_busy", 32'(m_busy), 32'h0);
        tick();
        check("exreq_after_valid", 32'(dreq_valid), 32'h0);

        // Flush in WAIT: transaction completes, data is discarded.
        instr(OP_LW, 32'h400, 32'h7000, 32'h0, 6'h0);
        tick();
        instr(OP_NOP, 32'h404, 32'h0, 32'h0, 6'h0);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        exception = 1'b1;
        tick();
        exception = 1'b0;
        check("exwait_busy", 32'(m_busy), 32'd1);
        tick();
        check("exwait_busy2", 32'(m_busy), 32'd1);
        bus(1'b0, 1'b1, 32'h1234_5678);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        check("exwait_end_busy", 32'(m_busy), 32'h0);
        check("exwait_discard", m_val, 32'h7000);
        check("exwait_end_valid", 32'(dreq_valid), 32'h0);

        // Reset mid-transaction returns to IDLE; late response is ignored.
        instr(OP_LW, 32'h500, 32'h8000, 32'h0, 6'h0);
        tick();
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_busy", 32'(m_busy), 32'h0);
        check("midrst_pc", m_pc, 32'h0);
        instr(OP_NOP, 32'h0, 32'h0, 32'h0, 6'h0);
        bus(1'b0, 1'b1, 32'hBADB_AD00);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        check("midrst_after_busy", 32'(m_busy), 32'h0);
        check("midrst_after_val", m_val, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage, directly downstream of the execute stage.
- Latches execute results into the M pipeline register and issues load/store requests on the data bus with a req/addr_ok/data_ok handshake.
- Aligns and extends load data, generates store byte strobes, and raises address-error exceptions.
- Drives a busy/stall request to the hazard unit while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus data width; only 32 is supported.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- M_stall  in  1  hold M register
- M_bubble  in  1  load M register with bubble
- exception  in  1  pipeline flush from the exception unit
- M_pc  in  32  instruction PC
- M_val3  in  32  ALU result / effective address
- M_valt  in  32  store data (rt value)
- M_icode  in  6  opcode
- M_acode  in  6  funct
- M_excCode  in  6  bit5 = exception valid, [4:0] = code
- M_dst  in  5  destination register
- M_inDelaySlot  in  1  delay-slot flag
- dreq_valid  out  1  bus request valid
- dreq_write  out  1  1 = store
- dreq_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dreq_strobe  out  4  byte enables (stores only; 0 for loads)
- dreq_wdata  out  32  lane-replicated store data
- daddr_ok  in  1  request accepted
- ddata_ok  in  1  response valid
- drdata  in  32  read data
- m_pc  out  32  latched PC
- m_val  out  32  writeback value (load result or passthrough val3)
- m_icode  out  6  latched opcode
- m_acode  out  6  latched funct
- m_dst  out  5  latched destination
- m_excCode  out  6  final exception code
- m_inDelaySlot  out  1  latched delay-slot flag
- m_badvaddr  out  32  faulting address
- m_busy  out  1  stall request to hazard unit

Behaviour:
- Reset (resetn=0 at posedge): all m_* outputs 0, m_busy 0, dreq_valid 0, FSM = IDLE.
- Register load priority: resetn, then busy-hold, then M_stall (hold), then M_bubble (zero all fields), then capture.
  - Busy-hold: while m_busy=1 the register holds regardless of M_stall.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW (shared opcode constants).
  - A captured memory op with M_excCode[5]=0 and no alignment fault moves FSM IDLE->REQ on the next cycle.
  - All other ops stay IDLE.
- Alignment faults (no bus request is issued):
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Loads set m_excCode=6'b100100 (AdEL); stores set 6'b100101 (AdES).
  - m_badvaddr=M_val3 on a fault, otherwise 0.
- An incoming M_excCode[5]=1 takes precedence over alignment faults: it passes through unchanged and no request is issued.
- FSM:
  - IDLE: dreq_valid=0, m_busy=0.
  - REQ: dreq_valid=1, m_busy=1.
    - daddr_ok & ddata_ok -> DONE, capturing drdata.
    - daddr_ok alone -> WAIT.
    - exception=1 before daddr_ok -> IDLE; request dropped, no write occurs.
  - WAIT: dreq_valid=0, m_busy=1.
    - ddata_ok -> DONE, capturing drdata.
    - exception=1 here does not cancel the transaction: wait for ddata_ok, then go to IDLE and discard the data.
  - DONE: m_busy=0, m_val valid; -> IDLE when the next instruction is captured.
- Request outputs are held stable in REQ until daddr_ok.
- Minimum load latency: 2 cycles from capture to m_val valid (REQ with same-cycle addr_ok/data_ok).
- Load alignment (a = addr[1:0]):
  - LB/LBU: byte drdata[8a+7:8a], sign- or zero-extended.
  - LH/LHU: half-word selected by addr[1], sign- or zero-extended.
  - LW: whole word.
- Store encoding:
  - SB: strobe = 4'b0001<<a, wdata = {4{valt[7:0]}}.
  - SH: strobe = 4'b0011<<addr[1]*2, wdata = {2{valt[15:0]}}.
  - SW: strobe = 4'b1111, wdata = valt.
  - m_val = M_val3 for stores.
- Non-memory ops: m_val = M_val3 combinationally after capture; m_busy=0.
- exception=1 while IDLE/DONE has no effect here; the upstream bubble handles the flush.
- Reset mid-transaction returns the FSM to IDLE; any in-flight response is ignored.

Test Plan:
- LB with addr=0x1003, drdata=0x80FF_FF12 -> dreq_addr=0x1000, strobe 0, m_val=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH with addr=0x2002, valt=0x1234_ABCD -> strobe=4'b1100, wdata=0xABCD_ABCD, dreq_write=1.
- LW with addr=0x3001 -> no dreq_valid, m_excCode=6'b100100, m_badvaddr=0x3001; SW same address -> 6'b100101.
- LW with daddr_ok delayed 3 cycles, then ddata_ok 2 cycles later -> dreq_valid high exactly 4 cycles, m_busy high through WAIT, M_* changes ignored, m_val=drdata.
- exception=1 in REQ -> IDLE, no write; exception=1 in WAIT -> stays until ddata_ok, data discarded.
- ADD carrying M_excCode=6'b101100 at an aligned address -> passthrough code 6'b101100, no bus request, m_busy=0.
